// File: rtl/dual_issue_fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO accepting up to two
// instructions per cycle and presenting the two oldest as decode slots 1 and 2.
module dual_issue_fetch_queue #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       FlushD,
  input  logic                       StallD,
  input  logic                       StallPipeline2,
  input  logic                       PushEn1,
  input  logic                       PushEn2,
  input  logic [31:0]                InstrF1,
  input  logic [31:0]                InstrF2,
  input  logic [31:0]                PCF1,
  input  logic [31:0]                PCF2,
  output logic                       PushReady,
  output logic [31:0]                InstrD1,
  output logic [31:0]                InstrD2,
  output logic [31:0]                PCD1,
  output logic [31:0]                PCD2,
  output logic                       ValidD1,
  output logic                       ValidD2,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [AW-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [AW-1:0] head_plus1, tail_plus1;
  logic [CW-1:0] count_reg, count_next;
  logic          push_one, push_two;
  logic [1:0]    push_cnt, pop_cnt;

  assign head_plus1 = head_reg + AW'(1);
  assign tail_plus1 = tail_reg + AW'(1);

  // Slot outputs depend only on registered state, never on this cycle's inputs.
  assign Count     = count_reg;
  assign ValidD1   = (count_reg != '0);
  assign ValidD2   = (count_reg > CW'(1));
  assign PushReady = (count_reg <= CW'(DEPTH - 2));
  assign InstrD1   = ValidD1 ? instr_mem[head_reg]   : NOP;
  assign PCD1      = ValidD1 ? pc_mem[head_reg]      : 32'h0;
  assign InstrD2   = ValidD2 ? instr_mem[head_plus1] : NOP;
  assign PCD2      = ValidD2 ? pc_mem[head_plus1]    : 32'h0;

  always_comb begin
    push_one = PushReady & PushEn1;
    push_two = push_one & PushEn2;
    push_cnt = {1'b0, push_one} + {1'b0, push_two};
    // StallD outranks StallPipeline2; a partial issue consumes only slot 1.
    if (StallD) begin
      pop_cnt = 2'd0;
    end else if (StallPipeline2) begin
      pop_cnt = {1'b0, ValidD1};
    end else begin
      pop_cnt = {1'b0, ValidD1} + {1'b0, ValidD2};
    end
    head_next  = head_reg + AW'(pop_cnt);
    tail_next  = tail_reg + AW'(push_cnt);
    count_next = count_reg + CW'(push_cnt) - CW'(pop_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; the pair may straddle the wrap since tail_plus1 wraps.
  always_ff @(posedge clk) begin
    if (!rst && !FlushD) begin
      if (push_one) begin
        instr_mem[tail_reg] <= InstrF1;
        pc_mem[tail_reg]    <= PCF1;
      end
      if (push_two) begin
        instr_mem[tail_plus1] <= InstrF2;
        pc_mem[tail_plus1]    <= PCF2;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_dual_issue_fetch_queue;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, FlushD, StallD, StallPipeline2, PushEn1, PushEn2;
  logic [31:0] InstrF1, InstrF2, PCF1, PCF2;
  logic        PushReady, ValidD1, ValidD2;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
  logic [3:0]  Count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [63:0] mq[$];   // {pc, instr}, oldest at index 0

  dual_issue_fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .FlushD(FlushD), .StallD(StallD),
    .StallPipeline2(StallPipeline2), .PushEn1(PushEn1), .PushEn2(PushEn2),
    .InstrF1(InstrF1), .InstrF2(InstrF2), .PCF1(PCF1), .PCF2(PCF2),
    .PushReady(PushReady), .InstrD1(InstrD1), .InstrD2(InstrD2),
    .PCD1(PCD1), .PCD2(PCD2), .ValidD1(ValidD1), .ValidD2(ValidD2),
    .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: compute the queue after the coming edge from current inputs, commit after the edge.
  task automatic cyc();
    logic [63:0] nq[$];
    int sz, pops;
    nq = mq;
    sz = nq.size();
    if (rst || FlushD) begin
      nq.delete();
    end else begin
      bit ready;
      ready = (DEPTH - sz) >= 2;
      if (StallD) pops = 0;
      else if (StallPipeline2) pops = (sz >= 1) ? 1 : 0;
      else pops = (sz >= 2) ? 2 : sz;
      repeat (pops) void'(nq.pop_front());
      if (ready && PushEn1) begin
        nq.push_back({PCF1, InstrF1});
        if (PushEn2) nq.push_back({PCF2, InstrF2});
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [63:0] e1, e2;
      e1 = (mq.size() >= 1) ? mq[0] : {32'h0, NOP};
      e2 = (mq.size() >= 2) ? mq[1] : {32'h0, NOP};
      chk("m_count",  32'(Count),     32'(mq.size()));
      chk("m_valid1", 32'(ValidD1),   32'(mq.size() >= 1));
      chk("m_valid2", 32'(ValidD2),   32'(mq.size() >= 2));
      chk("m_ready",  32'(PushReady), 32'((DEPTH - mq.size()) >= 2));
      chk("m_instr1", InstrD1, e1[31:0]);
      chk("m_pc1",    PCD1,    e1[63:32]);
      chk("m_instr2", InstrD2, e2[31:0]);
      chk("m_pc2",    PCD2,    e2[63:32]);
    end
  end

  task automatic idle_inputs();
    rst = 0; FlushD = 0; StallD = 0; StallPipeline2 = 0;
    PushEn1 = 0; PushEn2 = 0;
    InstrF1 = 0; InstrF2 = 0; PCF1 = 0; PCF2 = 0;
  endtask

  task automatic set_push(input bit two, input logic [31:0] pc, input logic [31:0] i1,
                          input logic [31:0] i2);
    PushEn1 = 1; PushEn2 = two;
    PCF1 = pc; InstrF1 = i1; PCF2 = pc + 32'd4; InstrF2 = i2;
  endtask

  initial begin
    int k, cycles;
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    cmp_en = 1;

    // Reset state
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_valid", {30'd0, ValidD1, ValidD2}, 32'd0);
    chk("rst_instr1", InstrD1, 32'h00000013);
    chk("rst_instr2", InstrD2, 32'h00000013);
    chk("rst_pc", PCD1 | PCD2, 32'd0);
    chk("rst_ready", 32'(PushReady), 32'd1);

    // Pair push, then full issue
    rst = 0;
    set_push(1, 32'h0, 32'h00500093, 32'h00A00113);
    cyc();
    chk("pair_instr1", InstrD1, 32'h00500093);
    chk("pair_pc1", PCD1, 32'h0);
    chk("pair_instr2", InstrD2, 32'h00A00113);
    chk("pair_pc2", PCD2, 32'h4);
    PushEn1 = 0; PushEn2 = 0;
    cyc();
    chk("drain_count", 32'(Count), 32'd0);
    chk("drain_instr1", InstrD1, NOP);

    // Partial issue then held stall
    StallD = 1;
    set_push(1, 32'h10, 32'hAAAA0001, 32'hBBBB0002);
    cyc();
    set_push(0, 32'h18, 32'hCCCC0003, 32'h0);
    cyc();
    PushEn1 = 0; StallD = 0; StallPipeline2 = 1;
    cyc();
    chk("p2_pc1", PCD1, 32'h14);
    chk("p2_pc2", PCD2, 32'h18);
    chk("p2_count", 32'(Count), 32'd2);
    StallPipeline2 = 0; StallD = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc1", PCD1, 32'h14);
      chk("stall_count", 32'(Count), 32'd2);
    end

    // Fill to full while decode stalls
    StallD = 0; FlushD = 1;
    cyc();
    FlushD = 0; StallD = 1;
    for (int i = 0; i < 4; i++) begin
      set_push(1, 32'h40 + 32'(i * 8), $urandom, $urandom);
      cyc();
      chk("fill_count", 32'(Count), 32'((i + 1) * 2));
      chk("fill_ready", 32'(PushReady), (i < 3) ? 32'd1 : 32'd0);
    end
    set_push(1, 32'h60, $urandom, $urandom);
    cyc();
    chk("full_drop_count", 32'(Count), 32'd8);
    chk("full_head_pc", PCD1, 32'h40);

    // 20 sequential pairs through the wrap with random partial issue
    PushEn1 = 0; StallD = 0; FlushD = 1;
    cyc();
    FlushD = 0;
    k = 0; cycles = 0;
    while ((k < 20 || mq.size() != 0) && cycles < 500) begin
      bit acc;
      acc = (DEPTH - mq.size()) >= 2 && k < 20;
      if (k < 20) set_push(1, 32'h1000 + 32'(k * 8), $urandom, $urandom);
      else begin PushEn1 = 0; PushEn2 = 0; end
      StallPipeline2 = ($urandom_range(0, 1) == 1);
      StallD = ($urandom_range(0, 5) == 0);
      cyc();
      if (acc) k++;
      cycles++;
    end
    chk("stream_timeout", 32'(cycles < 500), 32'd1);
    chk("stream_pairs", 32'(k), 32'd20);
    chk("stream_empty", 32'(Count), 32'd0);

    // Flush with concurrent push at Count=5
    StallD = 1; StallPipeline2 = 0;
    set_push(1, 32'h80, $urandom, $urandom); cyc();
    set_push(1, 32'h88, $urandom, $urandom); cyc();
    set_push(0, 32'h90, $urandom, 32'h0);    cyc();
    chk("pre_flush_count", 32'(Count), 32'd5);
    set_push(1, 32'h98, $urandom, $urandom);
    FlushD = 1;
    cyc();
    chk("flush_count", 32'(Count), 32'd0);
    chk("flush_valid1", 32'(ValidD1), 32'd0);
    chk("flush_ready", 32'(PushReady), 32'd1);
    FlushD = 0;
    set_push(0, 32'h200, 32'h12345678, 32'h0);
    cyc();
    chk("post_flush_instr", InstrD1, 32'h12345678);
    chk("post_flush_pc", PCD1, 32'h200);

    // Fully random traffic including rare flush/reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      FlushD = ($urandom_range(0, 30) == 0);
      StallD = ($urandom_range(0, 3) == 0);
      StallPipeline2 = ($urandom_range(0, 2) == 0);
      PushEn1 = ($urandom_range(0, 3) != 0);
      PushEn2 = $urandom_range(0, 1);
      InstrF1 = $urandom; InstrF2 = $urandom; PCF1 = $urandom; PCF2 = $urandom;
      cyc();
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
